// File: rtl/multi_pulse_stretch_if.sv
// Pulse stretcher bus: raw channel inputs and mode/clear controls in,
// stretched pulses and per-channel status out.
interface multi_pulse_stretch_if #(
  parameter int CH = 4
);
  logic [CH-1:0] data_in;
  logic [1:0]    edge_mode;
  logic          clr_ovf;
  logic [CH-1:0] dataout;
  logic [CH-1:0] busy;
  logic [CH-1:0] overflow;

  modport master (
    output data_in, edge_mode, clr_ovf,
    input  dataout, busy, overflow
  );

  modport slave (
    input  data_in, edge_mode, clr_ovf,
    output dataout, busy, overflow
  );
endinterface

// File: rtl/multi_pulse_stretch.sv
// Multi-channel edge detector and pulse stretcher: each detected edge is queued
// and replayed as a STRETCH-cycle high pulse followed by at least GAP cycles low.
module multi_pulse_stretch #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 10,
  parameter int GAP         = 10,
  parameter int CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_pulse_stretch_if.slave bus
);

  localparam int TMAX = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]    HIGH_LD  = TW'(STRETCH - 1);
  localparam logic [TW-1:0]    LOW_LD   = TW'(GAP - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  logic [CH-1:0]    s;
  logic [CH-1:0]    prev;
  logic [CH-1:0]    det;
  logic [1:0]       state   [CH];
  logic [1:0]       state_n [CH];
  logic [TW-1:0]    cnt     [CH];
  logic [TW-1:0]    cnt_n   [CH];
  logic [CNT_W-1:0] pend    [CH];
  logic [CNT_W-1:0] pend_n  [CH];
  logic [CH-1:0]    launch;
  logic [CH-1:0]    drop;
  logic [CH-1:0]    dout;
  logic [CH-1:0]    dout_n;
  logic [CH-1:0]    ovf;
  logic [CH-1:0]    busy_v;

  // Input synchroniser; zero stages means the input is already in the clk domain
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = bus.data_in;
    end else begin : g_sync
      logic [CH-1:0] chain [SYNC_STAGES];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
        end else begin
          chain[0] <= bus.data_in;
          for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
        end
      end
      assign s = chain[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else     prev <= s;
  end

  always_comb begin
    case (bus.edge_mode)
      2'b00:   det = s & ~prev;
      2'b01:   det = ~s & prev;
      2'b10:   det = s ^ prev;
      default: det = '0;
    endcase
  end

  // Per-channel sequencing and event queue
  always_comb begin
    launch = '0;
    drop   = '0;
    dout_n = '0;
    for (int c = 0; c < CH; c++) begin
      state_n[c] = state[c];
      cnt_n[c]   = cnt[c];
      pend_n[c]  = pend[c];
      case (state[c])
        IDLE: launch[c] = det[c] || (pend[c] != '0);
        HIGH: begin
          if (cnt[c] == '0) begin
            state_n[c] = LOW;
            cnt_n[c]   = LOW_LD;
          end else begin
            cnt_n[c] = cnt[c] - 1'b1;
          end
        end
        LOW: begin
          if (cnt[c] == '0) begin
            launch[c]  = det[c] || (pend[c] != '0);
            state_n[c] = IDLE;
          end else begin
            cnt_n[c] = cnt[c] - 1'b1;
          end
        end
        default: state_n[c] = IDLE;
      endcase
      if (launch[c]) begin
        state_n[c] = HIGH;
        cnt_n[c]   = HIGH_LD;
      end
      // A launch with both sources takes from the queue and refills it with det
      if (launch[c]) begin
        if (!det[c] && (pend[c] != '0)) pend_n[c] = pend[c] - 1'b1;
      end else if (det[c]) begin
        if (pend[c] == PEND_MAX) drop[c] = 1'b1;
        else                     pend_n[c] = pend[c] + 1'b1;
      end
      dout_n[c] = (state_n[c] == HIGH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        state[c] <= IDLE;
        cnt[c]   <= '0;
        pend[c]  <= '0;
      end
      dout <= '0;
      ovf  <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        state[c] <= state_n[c];
        cnt[c]   <= cnt_n[c];
        pend[c]  <= pend_n[c];
      end
      dout <= dout_n;
      ovf  <= drop | (ovf & ~{CH{bus.clr_ovf}});
    end
  end

  always_comb begin
    busy_v = '0;
    for (int c = 0; c < CH; c++) begin
      busy_v[c] = (state[c] != IDLE) || (pend[c] != '0);
    end
  end

  assign bus.dataout  = dout;
  assign bus.busy     = busy_v;
  assign bus.overflow = ovf;

endmodule

// File: tb/tb_multi_pulse_stretch.sv
// Randomised and directed bench for multi_pulse_stretch against a timestamp-based
// reference model of the edge queue and pulse schedule.
module tb_multi_pulse_stretch;

  localparam int CH   = 4;
  localparam int SS   = 2;
  localparam int ST   = 5;
  localparam int GP   = 3;
  localparam int CW   = 2;
  localparam int PMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_pulse_stretch_if #(.CH(CH)) bus ();

  multi_pulse_stretch #(
    .CH(CH), .SYNC_STAGES(SS), .STRETCH(ST), .GAP(GP), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sampled-input history, last pulse start time, queue depth
  logic [CH-1:0] hq[$];
  int  last_m [CH];
  int  pend_m [CH];
  bit  ovf_m  [CH];
  int  k = 0;

  // Directed-test observation
  logic [CH-1:0] pdout;
  int  rises  [CH];
  int  r_last [CH];
  int  r_prev [CH];
  int  hi_cnt [CH];

  task automatic model_reset();
    hq.delete();
    for (int i = 0; i < SS + 1; i++) hq.push_back('0);
    for (int c = 0; c < CH; c++) begin
      last_m[c] = -1000;
      pend_m[c] = 0;
      ovf_m[c]  = 1'b0;
    end
  endtask

  task automatic obs_reset();
    pdout = '0;
    for (int c = 0; c < CH; c++) begin
      rises[c] = 0; r_last[c] = -1; r_prev[c] = -1; hi_cnt[c] = 0;
    end
  endtask

  task automatic model_edge();
    logic [CH-1:0] sv, pv;
    bit det, launch, drop;
    hq.push_back(bus.data_in);
    pv = hq[0];
    sv = hq[1];
    hq = hq[1:$];
    for (int c = 0; c < CH; c++) begin
      case (bus.edge_mode)
        2'b00:   det = sv[c] && !pv[c];
        2'b01:   det = !sv[c] && pv[c];
        2'b10:   det = sv[c] != pv[c];
        default: det = 1'b0;
      endcase
      drop   = 1'b0;
      launch = (k >= last_m[c] + ST + GP) && (det || pend_m[c] > 0);
      if (launch) begin
        last_m[c] = k;
        if (!det && pend_m[c] > 0) pend_m[c]--;
      end else if (det) begin
        if (pend_m[c] == PMAX) drop = 1'b1;
        else                   pend_m[c]++;
      end
      if (drop)             ovf_m[c] = 1'b1;
      else if (bus.clr_ovf) ovf_m[c] = 1'b0;
    end
  endtask

  // One clock: drive inputs, advance the model, compare just after the edge
  task automatic cycle(input logic [CH-1:0] d, input logic [1:0] m, input logic clr);
    logic [CH-1:0] ed, eb, eo;
    bus.data_in   = d;
    bus.edge_mode = m;
    bus.clr_ovf   = clr;
    model_edge();
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) begin
      ed[c] = (k >= last_m[c]) && (k < last_m[c] + ST);
      eb[c] = (k < last_m[c] + ST + GP) || (pend_m[c] > 0);
      eo[c] = ovf_m[c];
      if (bus.dataout[c]) hi_cnt[c]++;
      if (bus.dataout[c] && !pdout[c]) begin
        rises[c]++;
        r_prev[c] = r_last[c];
        r_last[c] = k;
      end
    end
    pdout = bus.dataout;
    check("dataout",  32'(bus.dataout),  32'(ed));
    check("busy",     32'(bus.busy),     32'(eb));
    check("overflow", 32'(bus.overflow), 32'(eo));
    k++;
  endtask

  task automatic do_reset();
    bus.data_in = '0; bus.edge_mode = 2'b00; bus.clr_ovf = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    obs_reset();
  endtask

  initial begin
    int k0;
    logic [CH-1:0] d;
    logic [1:0] m;
    bus.data_in = '0; bus.edge_mode = 2'b00; bus.clr_ovf = 1'b0;
    model_reset();
    obs_reset();

    // Reset held with inputs toggling
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_in = (i % 2 == 0) ? 4'hF : 4'h0;
      @(posedge clk);
      #1;
      check("rst_dataout",  32'(bus.dataout),  32'd0);
      check("rst_busy",     32'(bus.busy),     32'd0);
      check("rst_overflow", 32'(bus.overflow), 32'd0);
    end
    bus.data_in = '0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cycle('0, 2'b00, 1'b0);

    // Single pulse on ch0, rising mode
    obs_reset();
    k0 = k;
    cycle(4'b0001, 2'b00, 1'b0);
    for (int i = 0; i < 20; i++) cycle('0, 2'b00, 1'b0);
    check("single_latency", 32'(r_last[0] - k0), 32'(SS));
    check("single_width",   32'(hi_cnt[0]),      32'(ST));
    check("single_count",   32'(rises[0]),       32'd1);
    check("single_others",  32'(rises[1] + rises[2] + rises[3]), 32'd0);

    // Both-edge mode: one wide pulse gives a rise and a queued fall
    do_reset();
    for (int i = 0; i < 3; i++)  cycle(4'b0100, 2'b10, 1'b0);
    for (int i = 0; i < 30; i++) cycle('0, 2'b10, 1'b0);
    check("both_count",  32'(rises[2]),              32'd2);
    check("both_period", 32'(r_last[2] - r_prev[2]), 32'(ST + GP));

    // Queue overflow on ch3; clear coincident with a drop must not win
    do_reset();
    for (int j = 0; j < 45; j++) begin
      cycle(((j % 2 == 0) && (j <= 10)) ? 4'b1000 : 4'b0000, 2'b00, (j == 12));
      if (j == 12) check("ovf_set_beats_clr", 32'(bus.overflow[3]), 32'd1);
    end
    check("ovf_pulses", 32'(rises[3]),       32'd5);
    check("ovf_sticky", 32'(bus.overflow[3]), 32'd1);
    cycle('0, 2'b00, 1'b1);
    check("ovf_cleared", 32'(bus.overflow[3]), 32'd0);

    // Reset asserted during the 5th HIGH cycle with two events queued
    do_reset();
    for (int j = 0; j <= 6; j++)
      cycle(((j % 2 == 0) && (j <= 4)) ? 4'b0001 : 4'b0000, 2'b00, 1'b0);
    check("mid_high_before", 32'(bus.dataout[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_dataout",  32'(bus.dataout),  32'd0);
    check("mid_rst_busy",     32'(bus.busy),     32'd0);
    check("mid_rst_overflow", 32'(bus.overflow), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    obs_reset();
    for (int i = 0; i < 30; i++) cycle('0, 2'b00, 1'b0);
    check("mid_rst_no_pulses", 32'(rises[0]), 32'd0);

    // Randomised traffic, mode changes and clears
    do_reset();
    d = '0;
    m = 2'b00;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(3) == 0) d[c] = ~d[c];
      if ($urandom_range(31) == 0) m = 2'($urandom_range(3));
      cycle(d, m, ($urandom_range(15) == 0));
    end
    // Drain with detection disabled: queued events still play out
    for (int i = 0; i < 40; i++) cycle(d, 2'b11, 1'b0);
    check("drain_idle", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
